// File: rtl/word_writer_pkg.sv
// Shared definitions for the 2-bit symbol link: letter codes, symbol tables
// and serializer state encoding, used by word_writer and word_reader.
package word_pkg;

  localparam logic [1:0] LTR_I = 2'd0;
  localparam logic [1:0] LTR_L = 2'd1;
  localparam logic [1:0] LTR_U = 2'd2;
  localparam logic [1:0] LTR_V = 2'd3;

  localparam logic [1:0] SYM_GAP = 2'b00;

  typedef enum logic [1:0] {IDLE, BODY, TERM} state_t;

  function automatic logic [1:0] body_len(input logic [1:0] ltr);
    logic [1:0] len;
    len = 2'd3;
    case (ltr)
      LTR_I:   len = 2'd1;
      LTR_L:   len = 2'd2;
      default: len = 2'd3;
    endcase
    return len;
  endfunction

  // Body symbols are never SYM_GAP, so a 00 always marks the end of a letter.
  function automatic logic [1:0] body_sym(input logic [1:0] ltr, input logic [1:0] idx);
    logic [1:0] s;
    s = SYM_GAP;
    case (ltr)
      LTR_I: begin
        if (idx == 2'd0) s = 2'b11;
      end
      LTR_L: begin
        case (idx)
          2'd0:    s = 2'b11;
          2'd1:    s = 2'b01;
          default: s = SYM_GAP;
        endcase
      end
      LTR_U: begin
        case (idx)
          2'd0:    s = 2'b10;
          2'd1:    s = 2'b01;
          2'd2:    s = 2'b10;
          default: s = SYM_GAP;
        endcase
      end
      default: begin
        case (idx)
          2'd0:    s = 2'b11;
          2'd1:    s = 2'b01;
          2'd2:    s = 2'b11;
          default: s = SYM_GAP;
        endcase
      end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/word_writer_fifo.sv
// Small circular letter buffer between the producer handshake and the
// serializer; pointers wrap naturally because DEPTH is a power of two.
module letter_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wr_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/word_writer.sv
// Transmitter for the 2-bit symbol link: buffers letters and serializes each
// as its body symbols followed by GAP_SYMS terminator symbols.
module word_writer
  import word_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int GAP_SYMS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] letter,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [1:0] bits,
  output logic       busy,
  output logic       sent
);

  localparam int GW = (GAP_SYMS > 1) ? $clog2(GAP_SYMS) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_SYMS - 1);

  state_t     state;
  logic [1:0] cur;
  logic [1:0] idx;
  logic [GW-1:0] gcnt;

  logic       push;
  logic       pop;
  logic [1:0] rd_data;
  logic       full;
  logic       empty;

  // A pop is taken exactly when the FSM starts a new body: from IDLE, or
  // straight out of the last terminator so back-to-back frames have no gap.
  assign push     = in_valid && !full;
  assign pop      = !empty && ((state == IDLE) || ((state == TERM) && (gcnt == GAP_LAST)));
  assign in_ready = !full;

  letter_fifo #(
    .DEPTH (DEPTH),
    .W     (2)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (letter),
    .pop     (pop),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cur   <= LTR_I;
      idx   <= 2'd0;
      gcnt  <= '0;
      bits  <= SYM_GAP;
      busy  <= 1'b0;
      sent  <= 1'b0;
    end else begin
      sent <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            cur   <= rd_data;
            idx   <= 2'd0;
            bits  <= body_sym(rd_data, 2'd0);
            busy  <= 1'b1;
            state <= BODY;
          end else begin
            bits <= SYM_GAP;
            busy <= 1'b0;
          end
        end
        BODY: begin
          if (idx == body_len(cur) - 2'd1) begin
            bits  <= SYM_GAP;
            gcnt  <= '0;
            sent  <= (GAP_LAST == '0);
            state <= TERM;
          end else begin
            idx  <= idx + 2'd1;
            bits <= body_sym(cur, idx + 2'd1);
          end
        end
        TERM: begin
          // sent is raised on entry to the final terminator cycle.
          if (gcnt != GAP_LAST) begin
            gcnt <= gcnt + GW'(1);
            sent <= ((gcnt + GW'(1)) == GAP_LAST);
          end else if (!empty) begin
            cur   <= rd_data;
            idx   <= 2'd0;
            bits  <= body_sym(rd_data, 2'd0);
            state <= BODY;
          end else begin
            bits  <= SYM_GAP;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          bits  <= SYM_GAP;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
